// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared widths, opcode/ALU encodings and instruction decode for cpu_core
package cpu_core_pkg;
  localparam int DATA_W = 8;
  localparam int REG_CNT = 8;
  localparam int PC_W = 32;
  localparam int REG_AW = $clog2(REG_CNT);
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR = 8'h05;
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  typedef struct packed {
    logic we;
    logic imm_sel;
    logic neg_sel;
    logic [2:0] aluop;
  } ctrl_t;
  // Unknown opcodes fall through to the default: no write, forward ALU op.
  function automatic ctrl_t decode(input logic [7:0] op);
    ctrl_t c;
    c = '{we: 1'b0, imm_sel: 1'b0, neg_sel: 1'b0, aluop: ALU_FWD};
    case (op)
      OP_LOADI: c = '{we: 1'b1, imm_sel: 1'b1, neg_sel: 1'b0, aluop: ALU_FWD};
      OP_MOV: c = '{we: 1'b1, imm_sel: 1'b0, neg_sel: 1'b0, aluop: ALU_FWD};
      OP_ADD: c = '{we: 1'b1, imm_sel: 1'b0, neg_sel: 1'b0, aluop: ALU_ADD};
      OP_SUB: c = '{we: 1'b1, imm_sel: 1'b0, neg_sel: 1'b1, aluop: ALU_ADD};
      OP_AND: c = '{we: 1'b1, imm_sel: 1'b0, neg_sel: 1'b0, aluop: ALU_AND};
      OP_OR: c = '{we: 1'b1, imm_sel: 1'b0, neg_sel: 1'b0, aluop: ALU_OR};
      default: c = '{we: 1'b0, imm_sel: 1'b0, neg_sel: 1'b0, aluop: ALU_FWD};
    endcase
    return c;
  endfunction
endpackage

// File: rtl/cpu_core_alu.sv
// alu: combinational 8-bit forward/add/and/or unit; reserved selects yield zero
module alu
  import cpu_core_pkg::*;
(
  input logic [DATA_W-1:0] DATA1,
  input logic [DATA_W-1:0] DATA2,
  input logic [2:0] SELECT,
  output logic [DATA_W-1:0] RESULT
);
  always_comb begin
    RESULT = SELECT == ALU_FWD ? DATA2 :
             SELECT == ALU_ADD ? DATA1 + DATA2 :
             SELECT == ALU_AND ? DATA1 & DATA2 :
             SELECT == ALU_OR ? DATA1 | DATA2 : '0;
  end
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit core with 8-entry register file, operand muxes and a +4 PC
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic CLK,
  input logic RESET,
  input logic [31:0] INSTRUCTION,
  output logic [PC_W-1:0] PC,
  output logic [DATA_W-1:0] RESULT
);
  logic [DATA_W-1:0] rf [REG_CNT];
  logic [7:0] opcode;
  logic [REG_AW-1:0] rd, rt, rs;
  logic [DATA_W-1:0] imm, data1, rs_val, neg_val, data2;
  ctrl_t ctrl;
  always_comb begin
    opcode = INSTRUCTION[31:24];
    rd = INSTRUCTION[18:16];
    rt = INSTRUCTION[10:8];
    rs = INSTRUCTION[2:0];
    imm = INSTRUCTION[7:0];
    ctrl = decode(opcode);
    data1 = rf[rt];
    rs_val = rf[rs];
    neg_val = ~rs_val + 8'd1;
    data2 = ctrl.imm_sel ? imm : (ctrl.neg_sel ? neg_val : rs_val);
  end
  alu u_alu (
    .DATA1(data1),
    .DATA2(data2),
    .SELECT(ctrl.aluop),
    .RESULT(RESULT)
  );
  // Reset wins over any write the current instruction would make.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      PC <= RESET_PC;
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else begin
      PC <= PC + 32'd4;
      if (ctrl.we) rf[rd] <= RESULT;
    end
  end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: table-driven scoreboard bench for cpu_core; opcode 0xFF probes reg[RS] via RESULT
module tb_cpu_core;
  logic CLK, RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC, PC_W;
  logic [7:0] RESULT, RESULT_W;
  cpu_core dut (
    .CLK(CLK),
    .RESET(RESET),
    .INSTRUCTION(INSTRUCTION),
    .PC(PC),
    .RESULT(RESULT)
  );
  cpu_core #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(CLK),
    .RESET(RESET),
    .INSTRUCTION(INSTRUCTION),
    .PC(PC_W),
    .RESULT(RESULT_W)
  );
  typedef struct {
    logic [31:0] instr;
    logic [7:0] res;
  } vec_t;
  vec_t vecs [$];
  logic [7:0] sb [$];
  int asserts = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_pc();
    cmp("pc", PC, exp_pc);
    cmp("pc_wrap", PC_W, 32'hFFFF_FFF8 + exp_pc);
  endtask
  task automatic step(input string name, input logic [31:0] ins, input logic [7:0] exp);
    logic [7:0] e;
    INSTRUCTION = ins;
    sb.push_back(exp);
    #1;
    check_pc();
    asserts++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (RESULT !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", name, RESULT, e);
      end
    end
    @(posedge CLK);
    #1;
    exp_pc = exp_pc + 32'd4;
  endtask
  initial begin
    RESET = 1'b0;
    INSTRUCTION = 32'h0001_0055;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) step($sformatf("reset_r%0d", i), 32'hFF00_0000 | i, 8'h00);
    vecs = '{
      '{32'h0001_0005, 8'h05}, '{32'h0002_0003, 8'h03}, '{32'h0203_0102, 8'h08},
      '{32'h0104_0003, 8'h08}, '{32'hFF00_0004, 8'h08}, '{32'h0304_0102, 8'h02},
      '{32'h0305_0201, 8'hFE}, '{32'hFF00_0005, 8'hFE}, '{32'h0006_00FF, 8'hFF},
      '{32'h0007_0001, 8'h01}, '{32'h0206_0607, 8'h00}, '{32'hFF00_0006, 8'h00},
      '{32'h0001_000C, 8'h0C}, '{32'h0002_000A, 8'h0A}, '{32'h0403_0102, 8'h08},
      '{32'h0503_0102, 8'h0E}, '{32'hFF00_0003, 8'h0E}, '{32'h0701_0102, 8'h0A},
      '{32'hFF00_0001, 8'h0C}, '{32'h0201_0101, 8'h18}, '{32'hFF00_0001, 8'h18},
      '{32'h0300_0101, 8'h00}, '{32'hFF00_0000, 8'h00}, '{32'h0105_0002, 8'h0A}
    };
    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i].instr, vecs[i].res);
    INSTRUCTION = 32'h0001_0055;
    RESET = 1'b0;
    #1;
    cmp("rst_mid_result", {24'h0, RESULT}, 32'h55);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    exp_pc = 32'h0;
    step("rst_mid_r1", 32'hFF00_0001, 8'h00);
    step("rst_mid_r2", 32'hFF00_0002, 8'h00);
    step("post_rst_loadi", 32'h0001_0077, 8'h77);
    step("post_rst_r1", 32'hFF00_0001, 8'h77);
    cmp("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
